// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: uart receive handshake plus 68000-style word register bus
interface uart_rx_fifo_if;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_avail_clear;
  logic        addr;
  logic        rw;
  logic        uds;
  logic        lds;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        irq;
  modport master (
    output rx_data, rx_avail, addr, rw, uds, lds, data_write,
    input  rx_avail_clear, data_read, irq
  );
  modport slave (
    input  rx_data, rx_avail, addr, rw, uds, lds, data_write,
    output rx_avail_clear, data_read, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers uart RX bytes in a FIFO read by the CPU through DATA/STATUS words
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic            clk,
  input logic            reset,
  uart_rx_fifo_if.slave  bus
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_n;
  logic          overflow, irq_en, irq_en_n, strb_q;
  logic          empty, full, start, pop, wr, flush, take, push;
  logic [15:0]   status;
  always_comb begin
    empty    = count == '0;
    full     = count == (AW+1)'(DEPTH);
    start    = (bus.uds | bus.lds) & ~strb_q;
    pop      = start & bus.rw & ~bus.addr & bus.uds & ~empty;
    wr       = start & ~bus.rw & bus.addr & bus.lds;
    flush    = wr & bus.data_write[0];
    take     = (state == IDLE) & bus.rx_avail;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    push     = take & (~full | pop) & ~flush;
    irq_en_n = wr ? bus.data_write[1] : irq_en;
    count_n  = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    status   = {3'b0, 5'(count), 4'b0, irq_en, overflow, full, ~empty};
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.rx_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      overflow           <= 1'b0;
      irq_en             <= 1'b0;
      strb_q             <= 1'b0;
      bus.rx_avail_clear <= 1'b0;
      bus.irq            <= 1'b0;
      bus.data_read      <= '0;
    end else begin
      strb_q   <= bus.uds | bus.lds;
      count    <= count_n;
      irq_en   <= irq_en_n;
      bus.irq  <= irq_en_n & (count_n != '0);
      rd_ptr   <= flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= flush ? '0 : wr_ptr + AW'(push);
      overflow <= (overflow & ~(wr & bus.data_write[2])) | (take & full & ~pop & ~flush);
      if (take) begin
        state              <= ACK;
        bus.rx_avail_clear <= 1'b1;
      end else if (state == ACK && !bus.rx_avail) begin
        state              <= IDLE;
        bus.rx_avail_clear <= 1'b0;
      end
      if (start & bus.rw)
        bus.data_read <= bus.addr ? status : (empty ? 16'h0000 : {mem[rd_ptr], 8'h00});
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven and scoreboard checks of the uart receive FIFO
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_rx_fifo_if bus();
  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    int          kind;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;
  int         vecs = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  vec_t       tbl[9];
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic wait_clear(logic lvl, string name);
    int n = 0;
    while (bus.rx_avail_clear !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 16'(bus.rx_avail_clear), 16'(lvl));
  endtask
  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_avail = 1'b1;
    if (sb.size() < 16) sb.push_back(b);
    wait_clear(1'b1, "ack_rise");
    bus.rx_avail = 1'b0;
    wait_clear(1'b0, "ack_fall");
  endtask
  task automatic bus_read(logic a, int hold, logic [15:0] exp, string name);
    @(negedge clk);
    bus.rw = 1'b1;
    bus.addr = a;
    bus.uds = 1'b1;
    bus.lds = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check(name, bus.data_read, exp);
    end
    bus.uds = 1'b0;
    bus.lds = 1'b0;
    @(negedge clk);
  endtask
  task automatic data_chk(int hold, string name);
    logic [15:0] exp;
    exp = (sb.size() > 0) ? {sb.pop_front(), 8'h00} : 16'h0000;
    bus_read(1'b0, hold, exp, name);
  endtask
  task automatic status_chk(logic [15:0] exp, string name);
    bus_read(1'b1, 1, exp, name);
  endtask
  task automatic bus_write(logic [15:0] w);
    @(negedge clk);
    bus.rw = 1'b0;
    bus.addr = 1'b1;
    bus.lds = 1'b1;
    bus.data_write = w;
    if (w[0]) sb.delete();
    @(negedge clk);
    bus.lds = 1'b0;
    bus.rw = 1'b1;
    bus.data_write = '0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.rx_data = '0;
    bus.rx_avail = 1'b0;
    bus.addr = 1'b0;
    bus.rw = 1'b1;
    bus.uds = 1'b0;
    bus.lds = 1'b0;
    bus.data_write = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", 16'(bus.rx_avail_clear), 16'h0);
    check("reset_data_read", bus.data_read, 16'h0000);
    check("reset_irq", 16'(bus.irq), 16'h0);
    reset = 1'b0;
    status_chk(16'h0000, "reset_status");
    // three bytes in, status, drain, status, then a read of the empty FIFO
    tbl[0] = '{0, 8'h41, 16'h0};
    tbl[1] = '{0, 8'h42, 16'h0};
    tbl[2] = '{0, 8'h43, 16'h0};
    tbl[3] = '{2, 8'h00, 16'h0301};
    tbl[4] = '{1, 8'h00, 16'h0};
    tbl[5] = '{1, 8'h00, 16'h0};
    tbl[6] = '{1, 8'h00, 16'h0};
    tbl[7] = '{2, 8'h00, 16'h0000};
    tbl[8] = '{1, 8'h00, 16'h0};
    for (int i = 0; i < 9; i++)
      if (tbl[i].kind == 0) send_byte(tbl[i].b);
      else if (tbl[i].kind == 1) data_chk(1, "tbl_data");
      else status_chk(tbl[i].exp, "tbl_status");
    // rx_avail held 10 cycles: one push, ack drops the cycle after rx_avail falls
    @(negedge clk);
    bus.rx_data = 8'h5A;
    bus.rx_avail = 1'b1;
    sb.push_back(8'h5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ack_held", 16'(bus.rx_avail_clear), 16'h1);
    end
    bus.rx_avail = 1'b0;
    @(negedge clk);
    check("ack_drop", 16'(bus.rx_avail_clear), 16'h0);
    status_chk(16'h0101, "single_push_status");
    data_chk(1, "held_data");
    // overflow on byte 17
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    status_chk(16'h1007, "overflow_status");
    data_chk(1, "overflow_first");
    bus_write(16'h0004);
    status_chk(16'h0F01, "ovf_clear_status");
    bus_write(16'h0001);
    status_chk(16'h0000, "flush_status");
    // interrupt and long strobes
    bus_write(16'h0002);
    send_byte(8'h55);
    check("irq_set", 16'(bus.irq), 16'h1);
    data_chk(8, "long_read_55");
    check("irq_clear", 16'(bus.irq), 16'h0);
    status_chk(16'h0008, "irq_en_status");
    send_byte(8'h66);
    send_byte(8'h77);
    data_chk(8, "long_read_66");
    status_chk(16'h0109, "one_pop_status");
    check("irq_still", 16'(bus.irq), 16'h1);
    data_chk(1, "read_77");
    check("irq_clear2", 16'(bus.irq), 16'h0);
    bus_write(16'h0000);
    // full FIFO: pop and push on the same edge
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    status_chk(16'h1003, "full_status");
    begin
      logic [15:0] head;
      @(negedge clk);
      bus.rx_data = 8'hA5;
      bus.rx_avail = 1'b1;
      bus.rw = 1'b1;
      bus.addr = 1'b0;
      bus.uds = 1'b1;
      bus.lds = 1'b1;
      head = {sb.pop_front(), 8'h00};
      sb.push_back(8'hA5);
      @(negedge clk);
      check("coinc_read", bus.data_read, head);
      check("coinc_ack", 16'(bus.rx_avail_clear), 16'h1);
      bus.uds = 1'b0;
      bus.lds = 1'b0;
      bus.rx_avail = 1'b0;
      wait_clear(1'b0, "coinc_ack_fall");
    end
    status_chk(16'h1003, "coinc_status");
    for (int i = 0; i < 16; i++) data_chk(1, "coinc_order");
    status_chk(16'h0000, "coinc_drained");
    // reset during ACK with three bytes queued
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    status_chk(16'h0301, "pre_reset_status");
    @(negedge clk);
    bus.rx_data = 8'h04;
    bus.rx_avail = 1'b1;
    wait_clear(1'b1, "pre_reset_ack");
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_ack", 16'(bus.rx_avail_clear), 16'h0);
    check("mid_reset_data_read", bus.data_read, 16'h0000);
    check("mid_reset_irq", 16'(bus.irq), 16'h0);
    reset = 1'b0;
    bus.rx_avail = 1'b0;
    sb.delete();
    @(negedge clk);
    status_chk(16'h0000, "post_reset_status");
    send_byte(8'h21);
    status_chk(16'h0101, "post_reset_push");
    data_chk(1, "post_reset_data");
    // flush on the same edge as a push
    send_byte(8'h31);
    send_byte(8'h32);
    @(negedge clk);
    bus.rx_data = 8'h99;
    bus.rx_avail = 1'b1;
    bus.rw = 1'b0;
    bus.addr = 1'b1;
    bus.lds = 1'b1;
    bus.data_write = 16'h0001;
    sb.delete();
    @(negedge clk);
    bus.lds = 1'b0;
    bus.rw = 1'b1;
    bus.data_write = '0;
    check("flush_push_ack", 16'(bus.rx_avail_clear), 16'h1);
    bus.rx_avail = 1'b0;
    wait_clear(1'b0, "flush_push_ack_fall");
    status_chk(16'h0000, "flush_push_status");
    data_chk(1, "flush_push_empty");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
